// File: rtl/asteroid_pkg.sv
// Shared constants, slot state encoding and LFSR settings for the asteroid spawner.
package asteroid_pkg;

    localparam int unsigned SCREEN_W_DEF = 640;
    localparam int unsigned SCREEN_H_DEF = 480;
    localparam int unsigned SPRITE_W_DEF = 37;

    localparam int unsigned POS_W   = 10;
    localparam int unsigned ARITH_W = 11;
    localparam int unsigned SPD_W   = 3;
    localparam int unsigned CNT_W   = 6;
    localparam int unsigned LFSR_W  = 16;

    // Galois form of x^16+x^14+x^13+x^11+1, right-shifting
    localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FALL = 1'b1
    } slot_state_t;

endpackage

// File: rtl/asteroid_spawner_lfsr16.sv
// Free-running 16-bit Galois LFSR; steps every clock, halt or not.
module lfsr16
    import asteroid_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    output logic [LFSR_W-1:0] state
);

    logic [LFSR_W-1:0] state_d;

    always_comb begin
        state_d = {1'b0, state[LFSR_W-1:1]};
        if (state[0]) begin
            state_d = state_d ^ LFSR_TAPS;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= LFSR_SEED;
        end else begin
            state <= state_d;
        end
    end

endmodule

// File: rtl/asteroid_spawner.sv
// Asteroid slot lifecycle: spawn arbitration, per-slot fall FSMs, registered frame outputs.
// Optional ASTEROID_SPAWNER_SPEEDUP_EN raises spawn speed with the number of dodges.
module asteroid_spawner
    import asteroid_pkg::*;
#(
    parameter int unsigned NUM_SLOTS  = 3,
    parameter int unsigned SCREEN_W   = SCREEN_W_DEF,
    parameter int unsigned SCREEN_H   = SCREEN_H_DEF,
    parameter int unsigned SPRITE_W   = SPRITE_W_DEF,
    parameter int unsigned BASE_SPEED = 2,
    parameter int unsigned SPAWN_GAP  = 30
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       halt,
    input  logic                       frame_tick,
    output logic [POS_W*NUM_SLOTS-1:0] xpos,
    output logic [POS_W*NUM_SLOTS-1:0] ypos,
    output logic [NUM_SLOTS-1:0]       active,
    output logic [NUM_SLOTS-1:0]       dodged
);

    localparam int unsigned X_MAX = SCREEN_W - SPRITE_W;

    logic [LFSR_W-1:0]    lfsr_val;
    logic                 lfsr_unused;
    logic                 ft_q;
    logic                 tick_c;
    logic [CNT_W-1:0]     countdown_q;
    logic [NUM_SLOTS-1:0] idle_c;
    logic [NUM_SLOTS-1:0] grant_c;
    logic                 spawn_c;
    logic [POS_W-1:0]     x_raw_c;
    logic [POS_W-1:0]     x_spawn_c;
    logic [SPD_W-1:0]     spd_spawn_c;

    lfsr16 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .state (lfsr_val)
    );

    assign lfsr_unused = ^lfsr_val[LFSR_W-1:POS_W];

    // A long frame_tick counts once; halt swallows the tick entirely
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ft_q <= 1'b0;
        end else begin
            ft_q <= frame_tick;
        end
    end

    assign tick_c = frame_tick & ~ft_q & ~halt;

    // Lowest-index slot that is idle at the start of the tick wins the spawn
    always_comb begin
        grant_c = '0;
        spawn_c = 1'b0;
        if (tick_c && (countdown_q == '0)) begin
            for (int i = 0; i < int'(NUM_SLOTS); i++) begin
                if (idle_c[i] && !spawn_c) begin
                    grant_c[i] = 1'b1;
                    spawn_c    = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            countdown_q <= CNT_W'(SPAWN_GAP);
        end else if (tick_c) begin
            if (spawn_c) begin
                countdown_q <= CNT_W'(SPAWN_GAP) + CNT_W'(lfsr_val[3:0]);
            end else if (countdown_q != '0) begin
                countdown_q <= countdown_q - CNT_W'(1);
            end
        end
    end

    // Fold out-of-range columns back by 512 so every sprite fits on screen
    assign x_raw_c   = lfsr_val[POS_W-1:0];
    assign x_spawn_c = (x_raw_c > POS_W'(X_MAX)) ? (x_raw_c - POS_W'(512)) : x_raw_c;

`ifdef ASTEROID_SPAWNER_SPEEDUP_EN
    logic [7:0] dodge_cnt_q;
    logic [8:0] dodge_sum_c;
    logic [4:0] spd_sum_c;

    always_comb begin
        dodge_sum_c = 9'(dodge_cnt_q);
        for (int i = 0; i < int'(NUM_SLOTS); i++) begin
            dodge_sum_c = dodge_sum_c + 9'(dodged[i]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dodge_cnt_q <= '0;
        end else begin
            dodge_cnt_q <= (dodge_sum_c > 9'd255) ? 8'hFF : dodge_sum_c[7:0];
        end
    end

    assign spd_sum_c   = 5'(BASE_SPEED) + 5'(dodge_cnt_q[7:4]) + 5'(lfsr_val[1:0]);
    assign spd_spawn_c = (spd_sum_c > 5'd7) ? SPD_W'(7) : spd_sum_c[SPD_W-1:0];
`else
    assign spd_spawn_c = SPD_W'(BASE_SPEED) + SPD_W'(lfsr_val[1:0]);
`endif

    for (genvar i = 0; i < int'(NUM_SLOTS); i++) begin : g_slot
        slot_state_t        state_q;
        slot_state_t        state_d;
        logic [POS_W-1:0]   x_q;
        logic [POS_W-1:0]   x_d;
        logic [POS_W-1:0]   y_q;
        logic [POS_W-1:0]   y_d;
        logic [SPD_W-1:0]   spd_q;
        logic [SPD_W-1:0]   spd_d;
        logic [ARITH_W-1:0] y_sum_c;
        logic               dodge_d;
        logic               active_q;
        logic               dodge_q;

        always_comb begin
            state_d = state_q;
            x_d     = x_q;
            y_d     = y_q;
            spd_d   = spd_q;
            dodge_d = 1'b0;
            y_sum_c = ARITH_W'(y_q) + ARITH_W'(spd_q);
            case (state_q)
                ST_IDLE: begin
                    if (grant_c[i]) begin
                        state_d = ST_FALL;
                        x_d     = x_spawn_c;
                        y_d     = '0;
                        spd_d   = spd_spawn_c;
                    end
                end
                ST_FALL: begin
                    if (tick_c) begin
                        if (y_sum_c >= ARITH_W'(SCREEN_H)) begin
                            state_d = ST_IDLE;
                            y_d     = '0;
                            dodge_d = 1'b1;
                        end else begin
                            y_d = y_sum_c[POS_W-1:0];
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q  <= ST_IDLE;
                x_q      <= '0;
                y_q      <= '0;
                spd_q    <= '0;
                active_q <= 1'b0;
                dodge_q  <= 1'b0;
            end else begin
                state_q  <= state_d;
                x_q      <= x_d;
                y_q      <= y_d;
                spd_q    <= spd_d;
                active_q <= (state_d == ST_FALL);
                dodge_q  <= dodge_d;
            end
        end

        assign idle_c[i]                 = (state_q == ST_IDLE);
        assign xpos[POS_W*i +: POS_W]    = x_q;
        assign ypos[POS_W*i +: POS_W]    = y_q;
        assign active[i]                 = active_q;
        assign dodged[i]                 = dodge_q;
    end

endmodule
